// File: rtl/sd_sched_pkg.sv
// sd_sched_pkg: shared definitions for the SD-card SPI bus scheduler.
//   sched_state_t : scheduler FSM states
//   GRANT_*       : bus owner codes driven on sd_bus_sched.grant
//   *_DEF         : default cycle constants and counter width
package sd_sched_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_REARM,
    ST_DUMMY
  } sched_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_INIT = 2'b01;
  localparam logic [1:0] GRANT_WR   = 2'b10;
  localparam logic [1:0] GRANT_RD   = 2'b11;

  localparam int unsigned PWRUP_CYC_DEF   = 80;
  localparam int unsigned DUMMY_CYC_DEF   = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 65535;
  localparam int unsigned CNT_W_DEF       = 17;

endpackage

// File: rtl/sd_sched_dncnt.sv
// sd_sched_dncnt: loadable down-counter that saturates at zero.
//   clk      in  counter clock (updates on the falling edge)
//   rst_n    in  asynchronous active-low reset, loads RST_VAL
//   load     in  load load_val (has priority over dec)
//   load_val in  value to load
//   dec      in  decrement by one unless already zero
//   zero     out count is zero
//   last     out count is one (the next decrement reaches zero)
module sd_sched_dncnt #(
  parameter int unsigned            CNT_W   = 17,
  parameter logic [CNT_W-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == ONE);

endmodule

// File: rtl/sd_bus_sched.sv
// sd_bus_sched: owns the SD-card SPI pins. Power-up dummy clocks, then the
// init engine, then single-block read/write arbitration with re-arm, dummy
// gap and timeout per transfer. All state changes on the falling sd_clk edge.
//   sd_clk, rst_n                       clock, async active-low reset
//   sd_csn, sd_mosi                     card pins, muxed from grant (idle = 1)
//   init_start/init_done/init_csn/init_mosi   init engine handshake and pins
//   wr_seq/wr_ok/wr_csn/wr_mosi/wr_eng_rst_n  write engine handshake and pins
//   rd_seq/rd_ok/rd_csn/rd_mosi/rd_eng_rst_n  read engine handshake and pins
//   wr_req, rd_req                      user requests (levels)
//   ready, done, err                    idle flag, success / timeout pulses
//   grant                               00 none, 01 init, 10 wr, 11 rd
// Build option: define SD_SCHED_RR_EN for round-robin tie breaking;
// otherwise read wins every tie.
module sd_bus_sched
  import sd_sched_pkg::*;
#(
  parameter int unsigned PWRUP_CYC   = PWRUP_CYC_DEF,
  parameter int unsigned DUMMY_CYC   = DUMMY_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       sd_clk,
  input  logic       rst_n,
  output logic       sd_csn,
  output logic       sd_mosi,
  output logic       init_start,
  input  logic       init_done,
  input  logic       init_csn,
  input  logic       init_mosi,
  output logic       wr_seq,
  input  logic       wr_ok,
  input  logic       wr_csn,
  input  logic       wr_mosi,
  output logic       wr_eng_rst_n,
  output logic       rd_seq,
  input  logic       rd_ok,
  input  logic       rd_csn,
  input  logic       rd_mosi,
  output logic       rd_eng_rst_n,
  input  logic       wr_req,
  input  logic       rd_req,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic [1:0] grant
);

  localparam logic [CNT_W-1:0] PWRUP_V   = CNT_W'(PWRUP_CYC);
  localparam logic [CNT_W-1:0] DUMMY_V   = CNT_W'(DUMMY_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

  sched_state_t     state;
  logic             wr_ok_q, rd_ok_q;
  logic             cnt_load, cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero, cnt_last, expired;
  logic             ok_rise, pick_wr, pick_rd;
`ifdef SD_SCHED_RR_EN
  logic             last_grant;  // 1: read was served last
`endif

  sd_sched_dncnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (PWRUP_V)
  ) u_cnt (
    .clk      (sd_clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  // A timed phase ends on the edge where the count reaches zero, so a load
  // of N gives exactly N cycles; zero also covers a load of 0.
  assign expired = cnt_zero | cnt_last;

  always_comb begin
    ok_rise = (state == ST_RD) ? (rd_ok & ~rd_ok_q) : (wr_ok & ~wr_ok_q);
`ifdef SD_SCHED_RR_EN
    pick_rd = rd_req & (~wr_req | ~last_grant);
`else
    pick_rd = rd_req;
`endif
    pick_wr = wr_req & ~pick_rd;
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state)
      ST_PWRUP, ST_DUMMY, ST_WR, ST_RD: cnt_dec = 1'b1;
      ST_INIT: begin
        cnt_load = init_done;
        cnt_val  = DUMMY_V;
      end
      ST_IDLE: begin
        cnt_load = wr_req | rd_req;
        cnt_val  = TIMEOUT_V;
      end
      ST_REARM: begin
        cnt_load = 1'b1;
        cnt_val  = DUMMY_V;
      end
      default: ;
    endcase
  end

  always_ff @(negedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_PWRUP;
      grant        <= GRANT_NONE;
      init_start   <= 1'b0;
      wr_seq       <= 1'b0;
      rd_seq       <= 1'b0;
      wr_eng_rst_n <= 1'b1;
      rd_eng_rst_n <= 1'b1;
      ready        <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      wr_ok_q      <= 1'b0;
      rd_ok_q      <= 1'b0;
`ifdef SD_SCHED_RR_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      wr_seq       <= 1'b0;
      rd_seq       <= 1'b0;
      wr_eng_rst_n <= 1'b1;
      rd_eng_rst_n <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      wr_ok_q      <= wr_ok;
      rd_ok_q      <= rd_ok;
      case (state)
        ST_PWRUP: begin
          if (expired) begin
            state      <= ST_INIT;
            grant      <= GRANT_INIT;
            init_start <= 1'b1;
          end
        end
        ST_INIT: begin
          if (init_done) begin
            state      <= ST_DUMMY;
            grant      <= GRANT_NONE;
            init_start <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (pick_wr) begin
            state  <= ST_WR;
            grant  <= GRANT_WR;
            wr_seq <= 1'b1;
            ready  <= 1'b0;
          end else if (pick_rd) begin
            state  <= ST_RD;
            grant  <= GRANT_RD;
            rd_seq <= 1'b1;
            ready  <= 1'b0;
          end
        end
        ST_WR, ST_RD: begin
          if (ok_rise || expired) begin
            done  <= ok_rise;
            err   <= ~ok_rise;
            state <= ST_REARM;
            grant <= GRANT_NONE;
            if (state == ST_RD) rd_eng_rst_n <= 1'b0;
            else                wr_eng_rst_n <= 1'b0;
`ifdef SD_SCHED_RR_EN
            last_grant <= (state == ST_RD);
`endif
          end
        end
        ST_REARM: state <= ST_DUMMY;
        ST_DUMMY: begin
          if (expired) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        default: state <= ST_PWRUP;
      endcase
    end
  end

  always_comb begin
    sd_csn  = 1'b1;
    sd_mosi = 1'b1;
    case (grant)
      GRANT_INIT: begin sd_csn = init_csn; sd_mosi = init_mosi; end
      GRANT_WR:   begin sd_csn = wr_csn;   sd_mosi = wr_mosi;   end
      GRANT_RD:   begin sd_csn = rd_csn;   sd_mosi = rd_mosi;   end
      default: ;
    endcase
  end

endmodule
